// File: rtl/ps2_key_event_pkg.sv
// Shared key identifiers, PS/2 scan codes, parser states and the scan-code to key map.
package uno_key_pkg;

  typedef enum logic [1:0] {
    KEY_LEFT   = 2'd0,
    KEY_RIGHT  = 2'd1,
    KEY_SELECT = 2'd2,
    KEY_START  = 2'd3
  } key_e;

  localparam logic [7:0] SC_Q      = 8'h15;
  localparam logic [7:0] SC_E      = 8'h24;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_LARROW = 8'h6B;
  localparam logic [7:0] SC_RARROW = 8'h74;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } parse_state_e;

  typedef struct packed {
    logic hit;
    key_e key;
  } key_hit_t;

  // Extended and normal code pages share 0x5A (Enter / keypad Enter) but
  // otherwise map disjoint codes; unmapped codes return hit = 0.
  function automatic key_hit_t map_code(input logic [7:0] code, input logic ext);
    key_hit_t r;
    r.hit = 1'b1;
    r.key = KEY_LEFT;
    if (ext) begin
      case (code)
        SC_LARROW: r.key = KEY_LEFT;
        SC_RARROW: r.key = KEY_RIGHT;
        SC_ENTER:  r.key = KEY_SELECT;
        default:   r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_Q:      r.key = KEY_LEFT;
        SC_E:      r.key = KEY_RIGHT;
        SC_ENTER:  r.key = KEY_SELECT;
        SC_SPACE:  r.key = KEY_START;
        default:   r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_event_fifo.sv
// Small synchronous FIFO of key events; a push is accepted while full if a pop
// happens in the same cycle.
import uno_key_pkg::*;

module key_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  key_e push_data,
  input  logic pop,
  output key_e pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  key_e          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event.sv
// PS/2 scan-code parser turning make/break bytes into spaced single-cycle
// game-control pulses, with held-key tracking and an event FIFO.
import uno_key_pkg::*;

module ps2_key_event #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int GAP_CYC     = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_code_valid,
  input  logic [7:0] i_code,
  output logic       o_left,
  output logic       o_right,
  output logic       o_select,
  output logic       o_start,
  output logic [3:0] o_held,
  output logic       o_overflow
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int GW = $clog2(GAP_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);

  parse_state_e  state;
  parse_state_e  next_state;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_next;
  logic          is_make;
  logic          is_break;
  logic          use_ext;
  key_hit_t      hit;
  logic          push;
  logic          pop;
  key_e          pop_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [GW-1:0] gap_cnt;
  logic [3:0]    pulse;

  // Prefix-tracking state and its abandonment timer.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else begin
      state   <= next_state;
      tmo_cnt <= tmo_next;
    end
  end

  // Decode each byte against the current prefix and age any pending prefix.
  always_comb begin
    next_state = state;
    tmo_next   = tmo_cnt;
    is_make    = 1'b0;
    is_break   = 1'b0;
    use_ext    = 1'b0;
    if (i_code_valid) begin
      tmo_next = '0;
      case (state)
        ST_IDLE: begin
          if (i_code == SC_EXT)      next_state = ST_EXT;
          else if (i_code == SC_BRK) next_state = ST_BRK;
          else                       is_make    = 1'b1;
        end
        ST_EXT: begin
          if (i_code == SC_BRK)      next_state = ST_EXT_BRK;
          else if (i_code == SC_EXT) next_state = ST_EXT;
          else begin
            is_make    = 1'b1;
            use_ext    = 1'b1;
            next_state = ST_IDLE;
          end
        end
        ST_BRK: begin
          is_break   = 1'b1;
          next_state = ST_IDLE;
        end
        ST_EXT_BRK: begin
          is_break   = 1'b1;
          use_ext    = 1'b1;
          next_state = ST_IDLE;
        end
        default: next_state = ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      if (tmo_cnt == TMO_LAST) begin
        next_state = ST_IDLE;
        tmo_next   = '0;
      end else begin
        tmo_next = tmo_cnt + TW'(1);
      end
    end
  end

  assign hit  = map_code(i_code, use_ext);
  assign push = is_make && hit.hit && !o_held[hit.key];
  assign pop  = !fifo_empty && (gap_cnt == '0);

  key_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (push),
    .push_data (hit.key),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Held-key levels follow make/break; overflow latches any dropped event.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_held     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push)                o_held[hit.key] <= 1'b1;
      if (is_break && hit.hit) o_held[hit.key] <= 1'b0;
      if (push && fifo_full && !pop) o_overflow <= 1'b1;
    end
  end

  // Issue one pulse per popped event and hold off the next for the gap period.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pulse   <= '0;
      gap_cnt <= '0;
    end else if (pop) begin
      pulse   <= 4'b0001 << pop_data;
      gap_cnt <= GAP_LOAD;
    end else begin
      pulse <= '0;
      if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
    end
  end

  assign o_left   = pulse[KEY_LEFT];
  assign o_right  = pulse[KEY_RIGHT];
  assign o_select = pulse[KEY_SELECT];
  assign o_start  = pulse[KEY_START];

endmodule

// File: tb/tb_ps2_key_event.sv
// Self-checking bench for ps2_key_event: a queue-based event model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_ps2_key_event;

  localparam int TIMEOUT = 200;
  localparam int GAP     = 64;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       code_valid = 1'b0;
  logic [7:0] code = 8'h00;
  logic       o_left, o_right, o_select, o_start, o_overflow;
  logic [3:0] o_held;

  int cmp_count  = 0;
  int fail_count = 0;
  int cycle      = 0;

  bit [3:0] m_held;
  bit [3:0] m_pulse;
  bit       m_ovf;
  bit       m_ext;
  bit       m_brk;
  int       m_idle;
  int       m_gap;
  int       m_q[$];

  int n_pulse[4];
  int pulse_cyc[$];
  int pulse_key[$];

  ps2_key_event #(
    .TIMEOUT_CYC (TIMEOUT),
    .GAP_CYC     (GAP),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_code_valid (code_valid),
    .i_code       (code),
    .o_left       (o_left),
    .o_right      (o_right),
    .o_select     (o_select),
    .o_start      (o_start),
    .o_held       (o_held),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  // Key index for a byte in the given code page, -1 when the byte is not a game key.
  function automatic int model_key(input logic [7:0] b, input bit ext);
    if (ext) begin
      if (b == 8'h6B) return 0;
      if (b == 8'h74) return 1;
      if (b == 8'h5A) return 2;
      return -1;
    end
    if (b == 8'h15) return 0;
    if (b == 8'h24) return 1;
    if (b == 8'h5A) return 2;
    if (b == 8'h29) return 3;
    return -1;
  endfunction

  // Reference behaviour: prefix flags, held set, bounded event queue, spacing timer.
  always @(posedge clk) begin : model_step
    int k;
    cycle++;
    if (!rst_n) begin
      m_held = '0; m_pulse = '0; m_ovf = 1'b0;
      m_ext = 1'b0; m_brk = 1'b0; m_idle = 0; m_gap = 0;
      m_q.delete();
    end else begin
      m_pulse = '0;
      if (m_q.size() > 0 && m_gap == 0) begin
        m_pulse[m_q.pop_front()] = 1'b1;
        m_gap = GAP - 1;
      end else if (m_gap > 0) begin
        m_gap--;
      end
      if (code_valid) begin
        m_idle = 0;
        if (m_brk) begin
          k = model_key(code, m_ext);
          if (k >= 0) m_held[k] = 1'b0;
          m_brk = 1'b0;
          m_ext = 1'b0;
        end else if (code == 8'hE0) begin
          m_ext = 1'b1;
        end else if (code == 8'hF0) begin
          m_brk = 1'b1;
        end else begin
          k = model_key(code, m_ext);
          m_ext = 1'b0;
          if (k >= 0 && !m_held[k]) begin
            m_held[k] = 1'b1;
            if (m_q.size() < DEPTH) m_q.push_back(k);
            else m_ovf = 1'b1;
          end
        end
      end else if (m_ext || m_brk) begin
        m_idle++;
        if (m_idle == TIMEOUT) begin
          m_ext = 1'b0; m_brk = 1'b0; m_idle = 0;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
    cmp_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Every cycle the DUT outputs must match the model.
  always @(negedge clk) begin
    check_output("model_pulse", {4'h0, o_start, o_select, o_right, o_left}, {4'h0, m_pulse});
    check_output("model_held", {4'h0, o_held}, {4'h0, m_held});
    check_output("model_ovf", {7'h0, o_overflow}, {7'h0, m_ovf});
  end

  // Record DUT pulses for the directed count, order and spacing checks.
  always @(negedge clk) begin
    logic [3:0] p;
    p = {o_start, o_select, o_right, o_left};
    for (int i = 0; i < 4; i++) begin
      if (p[i] === 1'b1) begin
        n_pulse[i]++;
        pulse_cyc.push_back(cycle);
        pulse_key.push_back(i);
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] b);
    code = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    code_valid = 1'b0;
    wait_cycles(3);
    check_output("in_reset_outputs", {1'b0, o_overflow, o_held, o_left, o_right}, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) n_pulse[i] = 0;
    pulse_cyc.delete();
    pulse_key.delete();
    wait_cycles(1);
    check_output("post_reset_outputs",
                 {1'b0, o_overflow, o_held, o_start | o_select, o_left | o_right}, 8'h00);
  endtask

  initial begin : stimulus
    int t0;

    // Make and break of a normal key with an empty FIFO.
    do_reset();
    apply_stimulus(8'h24);
    check_output("t1_held_after_make", {4'h0, o_held}, 8'h02);
    check_output("t1_no_pulse_yet", {7'h0, o_right}, 8'h00);
    wait_cycles(1);
    check_output("t1_right_pulse_n2", {4'h0, o_start, o_select, o_right, o_left}, 8'h02);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h24);
    check_output("t1_held_after_break", {4'h0, o_held}, 8'h00);
    wait_cycles(80);
    check_output("t1_right_count", 8'(n_pulse[1]), 8'd1);

    // Typematic repeats of Q give a single left event.
    do_reset();
    apply_stimulus(8'h15);
    apply_stimulus(8'h15);
    apply_stimulus(8'h15);
    wait_cycles(100);
    check_output("t2_held_left", {4'h0, o_held}, 8'h01);
    check_output("t2_left_count", 8'(n_pulse[0]), 8'd1);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h15);
    check_output("t2_held_cleared", {4'h0, o_held}, 8'h00);

    // Extended right arrow: only the extended break releases it.
    do_reset();
    apply_stimulus(8'hE0);
    apply_stimulus(8'h74);
    check_output("t3_held_ext_make", {4'h0, o_held}, 8'h02);
    wait_cycles(100);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h74);
    check_output("t3_normal_break_ignored", {4'h0, o_held}, 8'h02);
    apply_stimulus(8'hE0);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h74);
    check_output("t3_held_ext_break", {4'h0, o_held}, 8'h00);
    check_output("t3_right_count", 8'(n_pulse[1]), 8'd1);

    // Four keys on consecutive cycles are released exactly GAP apart.
    do_reset();
    t0 = cycle;
    apply_stimulus(8'h15);
    apply_stimulus(8'h24);
    apply_stimulus(8'h5A);
    apply_stimulus(8'h29);
    wait_cycles(300);
    check_output("t4_pulse_total", 8'(pulse_cyc.size()), 8'd4);
    if (pulse_cyc.size() == 4) begin
      check_output("t4_first_latency", 8'(pulse_cyc[0] - t0), 8'd2);
      for (int i = 1; i < 4; i++) begin
        check_output("t4_spacing", 8'(pulse_cyc[i] - pulse_cyc[i-1]), 8'd64);
        check_output("t4_order", 8'(pulse_key[i]), 8'(i));
      end
    end
    check_output("t4_no_overflow", {7'h0, o_overflow}, 8'h00);

    // Fill the FIFO during the gap, then push once more to overflow.
    do_reset();
    apply_stimulus(8'h15);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h15);
    apply_stimulus(8'h15);
    apply_stimulus(8'h24);
    apply_stimulus(8'h5A);
    apply_stimulus(8'h29);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h29);
    apply_stimulus(8'h29);
    check_output("t5_overflow_set", {7'h0, o_overflow}, 8'h01);
    wait_cycles(5 * GAP + 20);
    check_output("t5_pulse_total", 8'(pulse_key.size()), 8'd5);
    if (pulse_key.size() == 5) begin
      check_output("t5_seq0", 8'(pulse_key[0]), 8'd0);
      check_output("t5_seq1", 8'(pulse_key[1]), 8'd0);
      check_output("t5_seq2", 8'(pulse_key[2]), 8'd1);
      check_output("t5_seq3", 8'(pulse_key[3]), 8'd2);
      check_output("t5_seq4", 8'(pulse_key[4]), 8'd3);
    end
    check_output("t5_held_all", {4'h0, o_held}, 8'h0F);
    check_output("t5_overflow_sticky", {7'h0, o_overflow}, 8'h01);

    // Break prefix one cycle short of timeout still breaks; at timeout it is dropped.
    do_reset();
    apply_stimulus(8'hF0);
    wait_cycles(TIMEOUT - 1);
    apply_stimulus(8'h29);
    wait_cycles(100);
    check_output("t6_short_wait_is_break", 8'(n_pulse[3]), 8'd0);
    apply_stimulus(8'hF0);
    wait_cycles(TIMEOUT);
    apply_stimulus(8'h29);
    check_output("t6_timeout_make_held", {4'h0, o_held}, 8'h08);
    wait_cycles(100);
    check_output("t6_start_count", 8'(n_pulse[3]), 8'd1);

    // Reset with a pending E0 and three queued events discards everything.
    do_reset();
    apply_stimulus(8'h15);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h15);
    apply_stimulus(8'h24);
    apply_stimulus(8'h5A);
    apply_stimulus(8'h29);
    apply_stimulus(8'hE0);
    do_reset();
    wait_cycles(300);
    check_output("t7_no_pulses", 8'(n_pulse[0] + n_pulse[1] + n_pulse[2] + n_pulse[3]), 8'd0);
    check_output("t7_held_clear", {4'h0, o_held}, 8'h00);
    apply_stimulus(8'h74);
    check_output("t7_prefix_dropped", {4'h0, o_held}, 8'h00);
    wait_cycles(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
